// File: rtl/tx_chain_mask.sv
// tx_chain_mask: FIFO-fed Gray M-ASK mapper, x UPS zero-stuff upsampler, loadable FIR.
// Define TX_PRBS_EN to add a PRBS-9 symbol source selected by prbs_sel.
module tx_chain_mask #(
  parameter int BITS_PER_SYM = 2,
  parameter int UPS          = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int TAPS         = 17
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    sam_clk_en,
  input  logic                    sym_clk_en,
  input  logic [BITS_PER_SYM-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [17:0]      ref_level,
  input  logic                    coef_wr_en,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic signed [17:0]      coef_data,
  input  logic                    coef_commit,
`ifdef TX_PRBS_EN
  input  logic                    prbs_sel,
`endif
  output logic signed [17:0]      tx_sig,
  output logic signed [17:0]      tx_channel,
  output logic [15:0]             underrun_cnt
);

  localparam int B   = BITS_PER_SYM;
  localparam int M   = 1 << B;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int PHW = $clog2(UPS);
  localparam int AW  = $clog2(TAPS);
  localparam int ACW = 36 + AW;
  localparam int CTR = (TAPS - 1) / 2;

  localparam logic [PW:0]     FULL_CNT = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PHW-1:0]  PH_LAST  = PHW'(UPS - 1);
  localparam logic signed [17:0] POS_MAX = 18'sh1FFFF;
  localparam logic signed [17:0] NEG_MAX = 18'sh20000;

  // ---------------- symbol FIFO ----------------
  logic [B-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   fill;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          use_prbs;

  assign full     = (fill == FULL_CNT);
  assign empty    = (fill == '0);
  assign in_ready = !full && !reset;
  assign push     = in_valid && in_ready;
  assign pop      = sym_clk_en && !empty && !use_prbs;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // ---------------- optional PRBS source ----------------
  logic [B-1:0] prbs_sym;

`ifdef TX_PRBS_EN
  logic [8:0] lfsr;
  logic [8:0] lfsr_nx;

  assign use_prbs = prbs_sel;

  // x^9+x^5+1, oldest bit first; B steps per symbol, first bit lands in MSB
  always_comb begin
    lfsr_nx  = lfsr;
    prbs_sym = '0;
    for (int i = B - 1; i >= 0; i--) begin
      prbs_sym[i] = lfsr_nx[8];
      lfsr_nx     = {lfsr_nx[7:0], lfsr_nx[8] ^ lfsr_nx[4]};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      lfsr <= 9'h1FF;
    end else if (sym_clk_en && prbs_sel) begin
      lfsr <= lfsr_nx;
    end
  end
`else
  assign use_prbs = 1'b0;
  assign prbs_sym = '0;
`endif

  // ---------------- Gray M-ASK mapper ----------------
  function automatic logic signed [17:0] map_sym(
    input logic [B-1:0]        bits,
    input logic signed [17:0]  d
  );
    logic [B-1:0] g;
    int lvl;
    int prod;
    g[B-1] = bits[B-1];
    for (int i = B - 2; i >= 0; i--) g[i] = g[i+1] ^ bits[i];
    lvl  = 2 * int'(g) - (M - 1);
    prod = lvl * int'(d);
    if (prod > 131071)  return POS_MAX;
    if (prod < -131072) return NEG_MAX;
    return 18'(prod);
  endfunction

  logic sel_prbs;
  logic sel_fifo;

  assign sel_prbs = use_prbs;
  assign sel_fifo = !use_prbs && !empty;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      tx_sig       <= '0;
      underrun_cnt <= '0;
    end else if (sym_clk_en) begin
      unique case (1'b1)
        sel_prbs: tx_sig <= map_sym(prbs_sym, ref_level);
        sel_fifo: tx_sig <= map_sym(mem[rd_ptr], ref_level);
        default: begin
          tx_sig <= '0;
          if (underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'd1;
        end
      endcase
    end
  end

  // ---------------- zero-stuff upsampler ----------------
  logic [PHW-1:0]     phase;
  logic signed [17:0] up_sample;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      phase <= '0;
    end else if (sym_clk_en) begin
      phase <= '0;
    end else if (sam_clk_en) begin
      phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
    end
  end

  assign up_sample = (phase == '0) ? tx_sig : '0;

  // ---------------- coefficient banks ----------------
  logic signed [17:0] coef_act [TAPS];
  logic signed [17:0] coef_shd [TAPS];
  logic               pending;
  logic               swap;
  logic               addr_ok;

  assign swap    = sym_clk_en && (pending || coef_commit);
  assign addr_ok = int'(coef_addr) < TAPS;

  // shadow write in a swap cycle lands after the copy
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      pending <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        coef_act[k] <= (k == CTR) ? POS_MAX : '0;
        coef_shd[k] <= '0;
      end
    end else begin
      if (swap) begin
        pending <= 1'b0;
        for (int k = 0; k < TAPS; k++) coef_act[k] <= coef_shd[k];
      end else if (coef_commit) begin
        pending <= 1'b1;
      end
      if (coef_wr_en && addr_ok) coef_shd[coef_addr] <= coef_data;
    end
  end

  // ---------------- FIR ----------------
  logic signed [17:0]    dly [TAPS];
  logic signed [35:0]    prod;
  logic signed [ACW-1:0] acc;
  logic                  sat_ok;
  logic signed [17:0]    fir_out;
  logic                  unused_lsb;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) dly[k] <= '0;
    end else if (sam_clk_en) begin
      dly[0] <= up_sample;
      for (int k = 1; k < TAPS; k++) dly[k] <= dly[k-1];
    end
  end

  always_comb begin
    prod = '0;
    acc  = '0;
    for (int k = 0; k < TAPS; k++) begin
      prod = coef_act[k] * dly[k];
      acc  = acc + ACW'(prod);
    end
  end

  assign sat_ok     = (&acc[ACW-1:34]) || !(|acc[ACW-1:34]);
  assign fir_out    = sat_ok ? acc[34:17]
                             : (acc[ACW-1] ? NEG_MAX : POS_MAX);
  assign unused_lsb = ^acc[16:0];

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      tx_channel <= '0;
    end else if (sam_clk_en) begin
      tx_channel <= fir_out;
    end
  end

endmodule
